fact_arbiter: RTL

FACT_ARBITER -- requirements
Module: fact_arbiter

---
 rtl/fact_arbiter_if.sv | 48 ++++
 rtl/fact_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fact_arbiter_if.sv
// fact_arbiter_if -- bundle of requester, engine and response signals for
// fact_arbiter.
//
// Signals:
//   req / req_n      per-requester request level and operand (slice i = [i*DW +: DW])
//   gnt              one-hot, single-cycle grant pulse
//   eng_start/eng_n  start pulse and operand towards the factorial engine
//   eng_done/result  engine completion flag and result
//   rsp_valid/data   one-hot response valid and shared response data
//   rsp_err          response carries a timeout instead of a result
//   rsp_ack          per-requester response acknowledge
//   busy             arbiter is not idle
//
// Handshake semantics: a requester holds req[i] (and its operand) high until
// gnt[i] pulses; a response is offered on rsp_valid[i] with rsp_data/rsp_err
// held stable until the cycle in which rsp_ack[i] is sampled high, which
// completes the transfer. Acks on any other bit are ignored.
//
// Modports: master = requesters plus engine (drives req side and engine
// result), slave = the arbiter.
interface fact_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int RW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_n;
  logic [NREQ-1:0]    gnt;
  logic               eng_start;
  logic [DW-1:0]      eng_n;
  logic               eng_done;
  logic [RW-1:0]      eng_result;
  logic [NREQ-1:0]    rsp_valid;
  logic [RW-1:0]      rsp_data;
  logic               rsp_err;
  logic [NREQ-1:0]    rsp_ack;
  logic               busy;

  modport master (
    output req, req_n, eng_done, eng_result, rsp_ack,
    input  gnt, eng_start, eng_n, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  req, req_n, eng_done, eng_result, rsp_ack,
    output gnt, eng_start, eng_n, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/fact_arbiter.sv
// fact_arbiter -- round-robin arbiter that shares one factorial engine among
// NREQ requesters. One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   bus        fact_arbiter_if.slave (requests, engine handshake, responses)
//   dbg_state  current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//
// Optional feature: define FACT_ARB_TIMEOUT_EN to enable an engine timeout of
// TMO cycles in WAIT, answering with rsp_data=0 and rsp_err=1.
module fact_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int RW   = 32,
  parameter int TMO  = 255
) (
  input  logic            clk,
  input  logic            rst,
  fact_arbiter_if.slave   bus,
  output logic [1:0]      dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] ptr;   // last granted index
  logic [IW-1:0] idx;   // index being served
  logic [DW-1:0] op;    // latched operand, drives eng_n
  logic [RW-1:0] data;  // captured response data

  logic [IW-1:0] win;
  logic          found;
  logic [IW:0]   cand;
  logic          tmo_hit;

  // Round-robin search starting just above the last granted index.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!found && bus.req[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= IW'(NREQ - 1);
      idx   <= '0;
      op    <= '0;
      data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            idx   <= win;
            op    <= bus.req_n[win*DW +: DW];
            state <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (bus.eng_done) begin
            data  <= bus.eng_result;
            state <= RESP;
          end else if (tmo_hit) begin
            data  <= '0;
            state <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ack[idx]) begin
            ptr   <= idx;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FACT_ARB_TIMEOUT_EN
  localparam int CW = (TMO > 1) ? $clog2(TMO + 1) : 1;

  logic [CW-1:0] cnt;
  logic          err;

  // cnt counts completed WAIT cycles; it is cleared while in ISSUE so it
  // starts at zero on WAIT entry.
  assign tmo_hit = (cnt == CW'(TMO - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        cnt <= '0;
      end else if (state == WAIT && !bus.eng_done && !tmo_hit) begin
        cnt <= cnt + 1'b1;
      end

      if (state == WAIT && !bus.eng_done && tmo_hit) begin
        err <= 1'b1;
      end else if (state == RESP && bus.rsp_ack[idx]) begin
        err <= 1'b0;
      end
    end
  end

  assign bus.rsp_err = err;
`else
  localparam int unused_tmo = TMO;

  assign tmo_hit     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.gnt       = (state == ISSUE) ? (NREQ'(1) << idx) : '0;
  assign bus.eng_start = (state == ISSUE);
  assign bus.eng_n     = op;
  assign bus.rsp_valid = (state == RESP) ? (NREQ'(1) << idx) : '0;
  assign bus.rsp_data  = data;
  assign bus.busy      = (state != IDLE);
  assign dbg_state     = state;

endmodule
